// File: rtl/avalon_aes_pkg.sv
// Shared types and address-map helpers for the AES Avalon register bank.
package avalon_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Bit positions of the control flags inside the START and DONE words
  localparam int START_BIT = 0;
  localparam int DONE_BIT  = 0;

  function automatic int key_base();
    return 0;
  endfunction

  function automatic int msg_base(input int blk_words);
    return blk_words;
  endfunction

  function automatic int res_base(input int blk_words);
    return 2 * blk_words;
  endfunction

  function automatic int start_addr(input int num_regs);
    return num_regs - 2;
  endfunction

  function automatic int done_addr(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/avalon_aes_ctrl_regs_be_reg.sv
// Single byte-enable-writable register with a write-protect input.
module avalon_be_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_protect,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  // Update each enabled byte lane independently unless protected
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr_en && !wr_protect) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (byte_en[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_aes_ctrl_regs.sv
// Avalon-MM register bank for the AES core: key/message words, start/done
// handshake, result capture and LED export.
// Optional feature: define AES_KEY_READBACK_EN to make key words readable;
// otherwise key reads return 0.
module avalon_aes_ctrl_regs
  import avalon_aes_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int NUM_REGS  = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic                          AVL_CS,
  input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
  input  logic [$clog2(NUM_REGS)-1:0]   AVL_ADDR,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic                          AVL_READDATAVALID,
  output logic [BLK_WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [BLK_WORDS*DATA_W-1:0]   CORE_MSG,
  output logic                          CORE_START,
  input  logic                          CORE_DONE,
  input  logic [BLK_WORDS*DATA_W-1:0]   CORE_RESULT,
  output logic [DATA_W-1:0]             EXPORT_DATA
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(start_addr(NUM_REGS));
  localparam logic [ADDR_W-1:0] DONE_A  = ADDR_W'(done_addr(NUM_REGS));

  aes_state_e state, state_nxt;

  logic              wr_acc, rd_acc, start_wr, start_go, capture, run;
  logic              done_q, start_p1, vld_p1;
  logic [DATA_W-1:0] rdata_p1, rd_word;
  logic [DATA_W-1:0] key_q [BLK_WORDS];
  logic [DATA_W-1:0] msg_q [BLK_WORDS];
  logic [DATA_W-1:0] res_q [BLK_WORDS];

  assign wr_acc   = AVL_WRITE && AVL_CS;
  assign rd_acc   = AVL_READ && AVL_CS;
  assign run      = (state == ST_RUN);
  assign start_wr = wr_acc && (AVL_ADDR == START_A) && AVL_BYTE_EN[0]
                    && AVL_WRITEDATA[START_BIT];

  for (genvar i = 0; i < BLK_WORDS; i++) begin : g_words
    localparam logic [ADDR_W-1:0] KEY_A = ADDR_W'(key_base() + i);
    localparam logic [ADDR_W-1:0] MSG_A = ADDR_W'(msg_base(BLK_WORDS) + i);

    avalon_be_reg #(.DATA_W(DATA_W)) u_key (
      .clk        (CLK),
      .rst        (RESET),
      .wr_en      (wr_acc && (AVL_ADDR == KEY_A)),
      .wr_protect (run),
      .byte_en    (AVL_BYTE_EN),
      .wdata      (AVL_WRITEDATA),
      .q          (key_q[i])
    );

    avalon_be_reg #(.DATA_W(DATA_W)) u_msg (
      .clk        (CLK),
      .rst        (RESET),
      .wr_en      (wr_acc && (AVL_ADDR == MSG_A)),
      .wr_protect (run),
      .byte_en    (AVL_BYTE_EN),
      .wdata      (AVL_WRITEDATA),
      .q          (msg_q[i])
    );

    assign CORE_KEY[i*DATA_W +: DATA_W] = key_q[i];
    assign CORE_MSG[i*DATA_W +: DATA_W] = msg_q[i];
  end

  assign EXPORT_DATA = {key_q[BLK_WORDS-1][DATA_W-1:DATA_W/2], key_q[0][DATA_W/2-1:0]};

  // Handshake state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: start from IDLE/DONE, capture only while running
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_wr) begin
          start_go  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (CORE_DONE) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result words, done flag and the registered start pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= '0;
      done_q   <= 1'b0;
      start_p1 <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= CORE_RESULT[i*DATA_W +: DATA_W];
      end
      if (start_go)     done_q <= 1'b0;
      else if (capture) done_q <= 1'b1;
      start_p1 <= start_go;
    end
  end

  assign CORE_START = start_p1;

  // Read mux over the current (pre-edge) register contents
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
`ifdef AES_KEY_READBACK_EN
      if (AVL_ADDR == ADDR_W'(key_base() + i)) rd_word = key_q[i];
`endif
      if (AVL_ADDR == ADDR_W'(msg_base(BLK_WORDS) + i)) rd_word = msg_q[i];
      if (AVL_ADDR == ADDR_W'(res_base(BLK_WORDS) + i)) rd_word = res_q[i];
    end
    if (AVL_ADDR == START_A) rd_word[START_BIT] = run;
    if (AVL_ADDR == DONE_A)  rd_word[DONE_BIT]  = done_q;
  end

  // Read response stage: data held between responses, valid pulses once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= rd_word;
    end
  end

  assign AVL_READDATA      = rdata_p1;
  assign AVL_READDATAVALID = vld_p1;

endmodule

// File: tb/tb_avalon_aes_ctrl_regs.sv
// Directed bench for avalon_aes_ctrl_regs: a vector table for register
// access plus hand-written handshake, protection and reset sequences.
module tb_avalon_aes_ctrl_regs;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]   AVL_BYTE_EN;
  logic [3:0]   AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;
  logic         AVL_READDATAVALID;
  logic [127:0] CORE_KEY, CORE_MSG, CORE_RESULT;
  logic         CORE_START, CORE_DONE;
  logic [31:0]  EXPORT_DATA;

  always #5 CLK = ~CLK;

  avalon_aes_ctrl_regs #(.DATA_W(32), .BLK_WORDS(4), .NUM_REGS(16)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .AVL_READ          (AVL_READ),
    .AVL_WRITE         (AVL_WRITE),
    .AVL_CS            (AVL_CS),
    .AVL_BYTE_EN       (AVL_BYTE_EN),
    .AVL_ADDR          (AVL_ADDR),
    .AVL_WRITEDATA     (AVL_WRITEDATA),
    .AVL_READDATA      (AVL_READDATA),
    .AVL_READDATAVALID (AVL_READDATAVALID),
    .CORE_KEY          (CORE_KEY),
    .CORE_MSG          (CORE_MSG),
    .CORE_START        (CORE_START),
    .CORE_DONE         (CORE_DONE),
    .CORE_RESULT       (CORE_RESULT),
    .EXPORT_DATA       (EXPORT_DATA)
  );

`ifdef AES_KEY_READBACK_EN
  localparam bit KEY_RB = 1'b1;
`else
  localparam bit KEY_RB = 1'b0;
`endif

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[$];
  int   vec_cnt = 0;
  int   fail_cnt = 0;
  int   start_cnt = 0;

  localparam logic [127:0] R1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] R2 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

  // Count start pulses as seen by the core
  always @(posedge CLK) if (CORE_START) start_cnt++;

  function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    vec_t v;
    v.is_wr = w; v.addr = a; v.be = be; v.data = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge CLK);
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = d;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0;
  endtask

  // Read one word; vok is set only for a valid pulse of exactly one cycle
  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic vok);
    logic v1, v2;
    @(negedge CLK);
    AVL_READ = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    d  = AVL_READDATA;
    v1 = AVL_READDATAVALID;
    @(negedge CLK);
    v2 = AVL_READDATAVALID;
    vok = v1 && !v2;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        vok;
    do_read(a, d, vok);
    check(name, d, exp);
    check({name, "_vld"}, {31'b0, vok}, 32'd1);
  endtask

  task automatic pulse_done(input logic [127:0] r);
    @(negedge CLK);
    CORE_DONE = 1'b1; CORE_RESULT = r;
    @(negedge CLK);
    CORE_DONE = 1'b0; CORE_RESULT = '0;
  endtask

  initial begin
    RESET = 1'b1; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    AVL_BYTE_EN = 4'h0; AVL_ADDR = 4'h0; AVL_WRITEDATA = '0;
    CORE_DONE = 1'b0; CORE_RESULT = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    check("rst_readdata", AVL_READDATA, 32'h0);
    check("rst_rdvalid", {31'b0, AVL_READDATAVALID}, 32'h0);
    check("rst_start", {31'b0, CORE_START}, 32'h0);
    check("rst_export", EXPORT_DATA, 32'h0);
    for (int a = 0; a < 16; a++) read_chk($sformatf("rst_rd%0d", a), 4'(a), 32'h0);

    // Register-access vectors
    vecs.push_back(mk(1, 4'd0,  4'hA, 32'hDEADBEEF));
    vecs.push_back(mk(0, 4'd0,  4'h0, {32{KEY_RB}} & 32'hDE00BE00));
    vecs.push_back(mk(1, 4'd3,  4'hF, 32'h01234567));
    vecs.push_back(mk(1, 4'd1,  4'hF, 32'hCAFEF00D));
    vecs.push_back(mk(0, 4'd1,  4'h0, {32{KEY_RB}} & 32'hCAFEF00D));
    vecs.push_back(mk(1, 4'd4,  4'hA, 32'hDEADBEEF));
    vecs.push_back(mk(0, 4'd4,  4'h0, 32'hDE00BE00));
    vecs.push_back(mk(1, 4'd4,  4'h5, 32'h01234567));
    vecs.push_back(mk(0, 4'd4,  4'h0, 32'hDE23BE67));
    vecs.push_back(mk(1, 4'd5,  4'hF, 32'h11111111));
    vecs.push_back(mk(1, 4'd6,  4'hF, 32'h22222222));
    vecs.push_back(mk(1, 4'd7,  4'hF, 32'h33333333));
    vecs.push_back(mk(0, 4'd7,  4'h0, 32'h33333333));
    vecs.push_back(mk(0, 4'd5,  4'h0, 32'h11111111));
    vecs.push_back(mk(1, 4'd8,  4'hF, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 4'd8,  4'h0, 32'h0));
    vecs.push_back(mk(1, 4'd15, 4'hF, 32'h00000001));
    vecs.push_back(mk(0, 4'd15, 4'h0, 32'h0));
    vecs.push_back(mk(1, 4'd12, 4'hF, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 4'd12, 4'h0, 32'h0));
    vecs.push_back(mk(1, 4'd14, 4'hF, 32'h00000000));
    vecs.push_back(mk(0, 4'd14, 4'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].be, vecs[i].data);
      else read_chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
    end

    check("export", EXPORT_DATA, 32'h0123BE00);
    check("core_key_w0", CORE_KEY[31:0], 32'hDE00BE00);
    check("core_key_w1", CORE_KEY[63:32], 32'hCAFEF00D);
    check("core_msg_w0", CORE_MSG[31:0], 32'hDE23BE67);
    check("no_start_yet", start_cnt, 0);

    // Start handshake: one-cycle pulse one cycle after the write
    @(negedge CLK);
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = 4'd14; AVL_BYTE_EN = 4'h1; AVL_WRITEDATA = 32'h1;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    check("start_hi", {31'b0, CORE_START}, 32'd1);
    @(negedge CLK);
    check("start_lo", {31'b0, CORE_START}, 32'd0);
    read_chk("run_start_rd", 4'd14, 32'h1);
    read_chk("run_done_rd", 4'd15, 32'h0);

    // Capture with a same-cycle read of a result word: read sees old value
    @(negedge CLK);
    CORE_DONE = 1'b1; CORE_RESULT = R1; AVL_READ = 1'b1; AVL_CS = 1'b1; AVL_ADDR = 4'd8;
    @(negedge CLK);
    CORE_DONE = 1'b0; CORE_RESULT = '0; AVL_READ = 1'b0; AVL_CS = 1'b0;
    check("cap_old_rd", AVL_READDATA, 32'h0);
    check("cap_old_vld", {31'b0, AVL_READDATAVALID}, 32'd1);
    read_chk("res_w0", 4'd8, 32'hCCDDEEFF);
    read_chk("res_w3", 4'd11, 32'h00112233);
    read_chk("done_set", 4'd15, 32'h1);
    read_chk("start_rd_done", 4'd14, 32'h0);
    check("start_cnt1", start_cnt, 1);

    // Restart from DONE, then try writes while running
    do_write(4'd14, 4'h1, 32'h1);
    read_chk("done_clr", 4'd15, 32'h0);
    do_write(4'd4, 4'hF, 32'hFFFFFFFF);
    do_write(4'd14, 4'hF, 32'h1);
    read_chk("prot_msg", 4'd4, 32'hDE23BE67);
    check("start_cnt2", start_cnt, 2);

    // START write in the same cycle as CORE_DONE: capture wins
    @(negedge CLK);
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = 4'd14; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'h1;
    CORE_DONE = 1'b1; CORE_RESULT = R2;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0; CORE_DONE = 1'b0; CORE_RESULT = '0;
    read_chk("sim_res_w1", 4'd9, 32'hC2C2C2C2);
    read_chk("sim_done", 4'd15, 32'h1);
    read_chk("sim_start", 4'd14, 32'h0);
    check("start_cnt_sim", start_cnt, 2);

    // CORE_DONE while in DONE must not recapture
    pulse_done({4{32'h55555555}});
    read_chk("hold_res_w0", 4'd8, 32'hD3D3D3D3);

    // Reset while the start pulse is on the wire
    @(negedge CLK);
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = 4'd14; AVL_BYTE_EN = 4'h1; AVL_WRITEDATA = 32'h1;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_start", {31'b0, CORE_START}, 32'd0);
    RESET = 1'b0;
    check("rst_mid_export", EXPORT_DATA, 32'h0);
    read_chk("rst_mid_msg", 4'd4, 32'h0);
    read_chk("rst_mid_res", 4'd8, 32'h0);
    read_chk("rst_mid_start_rd", 4'd14, 32'h0);
    pulse_done(R1);
    read_chk("idle_done_ign", 4'd15, 32'h0);
    read_chk("idle_res_ign", 4'd11, 32'h0);
    check("core_key_cleared", CORE_KEY[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
